// File: rtl/monitor_sched_pkg.sv
// Shared types for the monitor evaluation scheduler: tag type, queued event
// record and scheduler FSM states.
package monitor_sched_pkg;

    localparam int NUM_IN = 2;
    localparam int TAG_W  = 64;

    typedef logic signed [TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t              tag;
        logic [NUM_IN-1:0] inputs;
        logic              periodic;
    } event_t;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    // Tags wrap two's-complement; the add simply overflows.
    function automatic tag_t next_tag(input tag_t t);
        return t + tag_t'(1);
    endfunction

endpackage

// File: rtl/monitor_event_fifo.sv
// Small synchronous event queue with registered read data; read data changes
// only on a pop and otherwise keeps the last popped entry.
module monitor_event_fifo
    import monitor_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  event_t                     wr_data,
    output event_t                     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    event_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    event_t          rd_data_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rd_data   = rd_data_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            rd_data_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem[rd_ptr_r];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/monitor_eval_scheduler.sv
// Timestamps input events and periodic deadlines, queues them, and sweeps a
// one-hot layer enable across the evaluation layers for each popped event.
module monitor_eval_scheduler
    import monitor_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int PERIOD     = 500,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_IN-1:0]       new_input,
    output logic                    q_push,
    output logic                    q_push_valid,
    output logic                    q_pop,
    output logic                    q_pop_valid,
    output logic signed [TAG_W-1:0] llc_tag,
    output logic [NUM_IN-1:0]       ev_inputs,
    output logic                    ev_periodic,
    output logic [NUM_LAYERS-1:0]   layer_en,
    output logic                    slide,
    output logic                    busy,
    output logic                    overflow
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TW-1:0]         timer_r;
    tag_t                  tag_cnt_r;
    state_t                state_r;
    state_t                next_state_s;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         next_idx_s;
    logic [NUM_LAYERS-1:0] next_layer_s;

    logic                  deadline_s;
    logic                  push_req_s;
    logic                  push_acc_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic [CW-1:0]         count_s;
    event_t                wr_data_s;
    event_t                rd_data_s;

    assign deadline_s = en && (timer_r == TW'(PERIOD - 1));
    assign push_req_s = en && ((|new_input) || deadline_s);
    // Occupancy is taken before the edge, so a same-edge pop never frees a slot.
    assign push_acc_s = push_req_s && (count_s < CW'(DEPTH));

    assign wr_data_s.tag      = next_tag(tag_cnt_r);
    assign wr_data_s.inputs   = new_input;
    assign wr_data_s.periodic = deadline_s;

    monitor_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_acc_s),
        .pop     (pop_s),
        .wr_data (wr_data_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    assign llc_tag     = rd_data_s.tag;
    assign ev_inputs   = rd_data_s.inputs;
    assign ev_periodic = rd_data_s.periodic;
    assign slide       = layer_en[0] && rd_data_s.periodic;

    // Deadline timer and tag counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r   <= {TW{1'b0}};
            tag_cnt_r <= '0;
        end else if (en) begin
            timer_r <= deadline_s ? {TW{1'b0}} : timer_r + TW'(1);
            if (push_acc_s) begin
                tag_cnt_r <= next_tag(tag_cnt_r);
            end
        end else begin
            timer_r   <= timer_r;
            tag_cnt_r <= tag_cnt_r;
        end
    end

    // Next-state, pop decision and next layer enable.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        pop_s        = 1'b0;
        next_layer_s = {NUM_LAYERS{1'b0}};
        if (en) begin
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = EVAL;
                        next_idx_s   = {IW{1'b0}};
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                EVAL: begin
                    if (idx_r == IW'(NUM_LAYERS - 1)) begin
                        next_idx_s = {IW{1'b0}};
                        if (!empty_s) begin
                            pop_s        = 1'b1;
                            next_state_s = EVAL;
                        end else begin
                            next_state_s = IDLE;
                        end
                    end else begin
                        next_idx_s = idx_r + IW'(1);
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_idx_s   = {IW{1'b0}};
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            next_layer_s[i] = (next_state_s == EVAL) && (next_idx_s == IW'(i));
        end
    end

    // FSM state and registered telemetry outputs; en low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {IW{1'b0}};
            q_push       <= 1'b0;
            q_push_valid <= 1'b0;
            q_pop        <= 1'b0;
            q_pop_valid  <= 1'b0;
            layer_en     <= {NUM_LAYERS{1'b0}};
            busy         <= 1'b0;
            overflow     <= 1'b0;
        end else if (en) begin
            state_r      <= next_state_s;
            idx_r        <= next_idx_s;
            q_push       <= push_req_s;
            q_push_valid <= push_acc_s;
            q_pop        <= pop_s;
            q_pop_valid  <= pop_s;
            layer_en     <= next_layer_s;
            busy         <= (next_state_s == EVAL);
            if (push_req_s && full_s) begin
                overflow <= 1'b1;
            end
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_monitor_eval_scheduler.sv
// Directed bench: dut_a (long period) covers event flow and queue overflow,
// dut_b (period 8) covers deadlines and enable freezing.
module tb_monitor_eval_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [1:0]  new_input = 2'b00;

    logic        a_q_push, a_q_push_valid, a_q_pop, a_q_pop_valid;
    logic signed [63:0] a_llc_tag;
    logic [1:0]  a_ev_inputs;
    logic        a_ev_periodic, a_slide, a_busy, a_overflow;
    logic [2:0]  a_layer_en;

    logic        b_q_push, b_q_push_valid, b_q_pop, b_q_pop_valid;
    logic signed [63:0] b_llc_tag;
    logic [1:0]  b_ev_inputs;
    logic        b_ev_periodic, b_slide, b_busy, b_overflow;
    logic [2:0]  b_layer_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    monitor_eval_scheduler #(.NUM_LAYERS(3), .PERIOD(1000), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .new_input(new_input),
        .q_push(a_q_push), .q_push_valid(a_q_push_valid),
        .q_pop(a_q_pop), .q_pop_valid(a_q_pop_valid),
        .llc_tag(a_llc_tag), .ev_inputs(a_ev_inputs), .ev_periodic(a_ev_periodic),
        .layer_en(a_layer_en), .slide(a_slide), .busy(a_busy), .overflow(a_overflow)
    );

    monitor_eval_scheduler #(.NUM_LAYERS(3), .PERIOD(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .new_input(new_input),
        .q_push(b_q_push), .q_push_valid(b_q_push_valid),
        .q_pop(b_q_pop), .q_pop_valid(b_q_pop_valid),
        .llc_tag(b_llc_tag), .ev_inputs(b_ev_inputs), .ev_periodic(b_ev_periodic),
        .layer_en(b_layer_en), .slide(b_slide), .busy(b_busy), .overflow(b_overflow)
    );

    typedef struct {
        logic        rst_first;
        logic [1:0]  ni;
        logic [2:0]  layer;
        logic        qp;
        logic        qpv;
        logic        qpop;
        logic        busy;
        logic [63:0] tag;
        logic [1:0]  evin;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        new_input = 2'b00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] tags[$];
        int          found;
        int          npop;

        // Test 2 rows 0..4, test 3 rows 5..15 (all on dut_a).
        vecs[0]  = '{1'b1, 2'b11, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00};
        vecs[1]  = '{1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1, 2'b11};
        vecs[2]  = '{1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1, 2'b11};
        vecs[3]  = '{1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1, 2'b11};
        vecs[4]  = '{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 2'b11};
        vecs[5]  = '{1'b1, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 2'b00};
        vecs[6]  = '{1'b0, 2'b01, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 64'd1, 2'b01};
        vecs[7]  = '{1'b0, 2'b01, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 64'd1, 2'b01};
        vecs[8]  = '{1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1, 2'b01};
        vecs[9]  = '{1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 64'd2, 2'b01};
        vecs[10] = '{1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2, 2'b01};
        vecs[11] = '{1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2, 2'b01};
        vecs[12] = '{1'b0, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 64'd3, 2'b01};
        vecs[13] = '{1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3, 2'b01};
        vecs[14] = '{1'b0, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'd3, 2'b01};
        vecs[15] = '{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 2'b01};

        // Reset state.
        do_reset();
        check("reset_a_flags", {a_q_push, a_q_push_valid, a_q_pop, a_q_pop_valid, a_busy, a_overflow, a_slide, a_ev_periodic}, 64'd0);
        check("reset_a_layer", a_layer_en, 64'd0);
        check("reset_a_tag", a_llc_tag, 64'd0);
        check("reset_b_flags", {b_q_push, b_q_pop, b_busy, b_overflow, b_layer_en, b_ev_inputs}, 64'd0);

        // Single event and back-to-back events.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_first) do_reset();
            new_input = vecs[i].ni;
            tick();
            check($sformatf("v%0d_layer_en", i), a_layer_en, vecs[i].layer);
            check($sformatf("v%0d_q_push", i), {a_q_push, a_q_push_valid}, {vecs[i].qp, vecs[i].qpv});
            check($sformatf("v%0d_q_pop", i), {a_q_pop, a_q_pop_valid}, {vecs[i].qpop, vecs[i].qpop});
            check($sformatf("v%0d_busy", i), a_busy, vecs[i].busy);
            check($sformatf("v%0d_tag", i), a_llc_tag, vecs[i].tag);
            check($sformatf("v%0d_ev_inputs", i), a_ev_inputs, vecs[i].evin);
            check($sformatf("v%0d_slide_ovf", i), {a_slide, a_overflow, a_ev_periodic}, 64'd0);
        end

        // Overflow: eight consecutive events into a depth-4 queue.
        do_reset();
        tags.delete();
        for (int e = 0; e < 8; e++) begin
            new_input = 2'b01;
            tick();
            if (a_q_pop) tags.push_back(a_llc_tag);
            if (e >= 6) begin
                check($sformatf("ovf_drop_e%0d", e), {a_q_push, a_q_push_valid}, 64'b10);
            end else begin
                check($sformatf("ovf_accept_e%0d", e), {a_q_push, a_q_push_valid}, 64'b11);
            end
        end
        check("ovf_sticky", a_overflow, 64'd1);
        new_input = 2'b00;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (a_q_pop) tags.push_back(a_llc_tag);
        end
        check("ovf_pop_count", tags.size(), 64'd6);
        for (int i = 0; i < tags.size(); i++) begin
            check($sformatf("ovf_tag%0d", i), tags[i], 64'(i + 1));
        end
        check("ovf_idle", {a_busy, a_layer_en}, 64'd0);
        check("ovf_still_set", a_overflow, 64'd1);

        // A further event gets the next tag (dropped pushes consumed none).
        new_input = 2'b10;
        tick();
        new_input = 2'b00;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            tick();
            if (a_q_pop) found = 1;
        end
        check("after_ovf_pop_seen", found, 64'd1);
        check("after_ovf_tag", a_llc_tag, 64'd7);
        tick();
        check("after_ovf_layer1", a_layer_en, 64'b010);

        // Reset mid-evaluation aborts immediately.
        rst = 1'b1;
        #1;
        check("midrst_flags", {a_q_push, a_q_push_valid, a_q_pop, a_q_pop_valid, a_busy, a_overflow, a_slide}, 64'd0);
        check("midrst_layer", a_layer_en, 64'd0);
        check("midrst_tag", a_llc_tag, 64'd0);
        check("midrst_evin", {a_ev_inputs, a_ev_periodic}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("midrst_no_resume", {a_layer_en, a_busy}, 64'd0);
        new_input = 2'b01;
        tick();
        new_input = 2'b00;
        tick();
        check("midrst_first_tag", a_llc_tag, 64'd1);
        check("midrst_first_layer", a_layer_en, 64'b001);

        // Deadline-only events on dut_b: slide on cycles 9, 17, 25, 33.
        do_reset();
        npop = 0;
        for (int c = 1; c <= 34; c++) begin
            tick();
            check($sformatf("per_slide_c%0d", c), b_slide, (c >= 9 && (c % 8) == 1) ? 64'd1 : 64'd0);
            if (b_q_pop) begin
                npop++;
                check($sformatf("per_tag_c%0d", c), b_llc_tag, 64'(npop));
                check($sformatf("per_ev_c%0d", c), {b_ev_periodic, b_ev_inputs, b_layer_en}, {58'd0, 1'b1, 2'b00, 3'b001});
            end
        end
        check("per_pop_count", npop, 64'd4);

        // Input coinciding with the deadline, then en low mid-sweep.
        do_reset();
        for (int c = 1; c <= 7; c++) tick();
        new_input = 2'b10;
        tick();
        check("coin_push", {b_q_push, b_q_push_valid}, 64'b11);
        new_input = 2'b00;
        tick();
        check("coin_layer0", b_layer_en, 64'b001);
        check("coin_event", {b_ev_periodic, b_ev_inputs, b_slide}, 64'b1101);
        check("coin_tag", b_llc_tag, 64'd1);
        tick();
        check("coin_layer1", b_layer_en, 64'b010);
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold_c%0d", c), {b_layer_en, b_busy, b_q_push}, 64'b01010);
        end
        en = 1'b1;
        tick();
        check("resume_layer2", b_layer_en, 64'b100);
        tick();
        check("resume_idle", {b_layer_en, b_busy}, 64'd0);
        for (int c = 3; c <= 5; c++) begin
            tick();
            check($sformatf("frozen_timer_e%0d", c), b_q_push, 64'd0);
        end
        tick();
        check("late_deadline_push", {b_q_push, b_q_push_valid}, 64'b11);
        tick();
        check("late_deadline_pop", b_q_pop, 64'd1);
        check("late_deadline_tag", b_llc_tag, 64'd2);
        check("late_deadline_ev", {b_ev_periodic, b_ev_inputs}, 64'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
